// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl -- two-requester sequential unsigned multiplier.
//
// Requesters 0 and 1 raise a level request with their operands and hold it
// until acked. When the unit is idle, a round-robin arbiter grants one
// requester, its operands are captured and a shift-add multiply runs for
// exactly WIDTH cycles on one shared WIDTH-bit adder. The result is
// presented for one cycle in DONE and held on the product port afterwards.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   req0/a0/b0     requester 0 request (level) and operands
//   req1/a1/b1     requester 1 request (level) and operands
//   ack0/ack1      one-cycle pulse, operands of that requester captured
//   busy           high in RUN and DONE
//   done           one-cycle pulse, product valid
//   done_id        requester that owns product
//   product        2*WIDTH-bit unsigned product, held until next done
//   overflow       upper half of product is nonzero, held with product

module mult_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 busy,
    output logic                 done,
    output logic                 done_id,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow
);

    // Counter must hold values up to WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;     // multiplicand, constant during RUN
    logic [WIDTH-1:0] acc;       // high half of the running product
    logic [WIDTH-1:0] mplier;    // multiplier, fills with low product bits
    logic [CW-1:0]    cnt;       // iterations completed
    logic             last;      // last-served requester
    logic             cur_id;    // requester owning the operation in flight

    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;       // adder result with carry-out
    logic [WIDTH:0]   low_shift;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mplier_nxt;
    logic             last_iter;

    // Round-robin: a lone request wins; on a tie the requester not served
    // last wins. last resets to 1 so requester 0 wins the first tie.
    always_comb begin
        grant0 = req0 & (~req1 | last);
        grant1 = req1 & (~req0 | ~last);
    end

    // One shift-add step. The carry-out becomes the new MSB of the high half
    // and the adder LSB shifts into the top of the multiplier register.
    always_comb begin
        addend     = mplier[0] ? mcand : '0;
        sum        = {1'b0, acc} + {1'b0, addend};
        low_shift  = {sum[0], mplier};
        acc_nxt    = sum[WIDTH:1];
        mplier_nxt = low_shift[WIDTH:1];
        last_iter  = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
            cnt      <= '0;
            last     <= 1'b1;
            cur_id   <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Requests are only looked at here; nothing is queued
                    // while an operation is in flight.
                    if (grant0 || grant1) begin
                        mcand  <= grant0 ? a0 : a1;
                        mplier <= grant0 ? b0 : b1;
                        acc    <= '0;
                        cnt    <= '0;
                        cur_id <= grant1;
                        last   <= grant1;
                        ack0   <= grant0;
                        ack1   <= grant1;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + 1'b1;
                    // The final step's result goes straight to the output
                    // registers on the same edge that enters DONE.
                    if (last_iter) begin
                        product  <= {acc_nxt, mplier_nxt};
                        overflow <= |acc_nxt;
                        done_id  <= cur_id;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl. Drivers push hand-computed results
// into a queue; the monitor pops one entry per done pulse and compares.
module tb_mult_seq_ctrl;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic           ack0, ack1, busy, done, done_id, overflow;
    logic [2*W-1:0] product;

    typedef struct packed {
        logic           id;
        logic [2*W-1:0] prod;
        logic           ovf;
    } exp_t;

    exp_t q[$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cyc = 0;
    int done_cyc = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    int ack_seen;
    int ack_seen1;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .busy(busy), .done(done),
        .done_id(done_id), .product(product), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, want);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack0 || ack1) begin
                chk("ack_overlap", 64'(ack0 & ack1), 64'd0);
                chk("ack_from_idle", 64'(prev_busy), 64'd0);
                chk("busy_with_ack", 64'(busy), 64'd1);
                ack_cyc <= cyc;
            end
            if (prev_done)
                chk("idle_after_done", 64'(busy), 64'd0);
            if (done) begin
                chk("done_busy", 64'(busy), 64'd1);
                chk("done_pulse", 64'(prev_done), 64'd0);
                done_cyc <= cyc;
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("product", product, e.prod);
                    chk("overflow", 64'(overflow), 64'(e.ovf));
                    chk("done_id", 64'(done_id), 64'(e.id));
                    // ack visible in cycle k+1, done in k+WIDTH+1
                    chk("latency", 64'(cyc - ack_cyc), 64'(W));
                end
            end
        end
        prev_busy <= busy;
        prev_done <= done;
    end

    task automatic push_exp(input logic id, input logic [2*W-1:0] p, input logic o);
        exp_t x;
        x.id = id; x.prod = p; x.ovf = o;
        q.push_back(x);
    endtask

    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [2*W-1:0] ep, input logic eo,
                         output int seen);
        int n;
        @(negedge clk);
        if (push) push_exp(id, ep, eo);
        if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; req0 = 1'b1; end
        seen = -1;
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if ((id && ack1) || (!id && ack0)) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) chk("ack_timeout", 64'd1, 64'd0);
        @(negedge clk);
        if (id) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) chk("idle_timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("busy_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ack", 64'({ack1, ack0}), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_done_id", 64'(done_id), 64'd0);
        rst = 1'b0;

        // 3 * 5
        issue(1'b0, 32'd3, 32'd5, 1'b1, 64'd15, 1'b0, ack_seen);
        wait_idle();
        // zero multiplicand, latency unchanged
        issue(1'b0, 32'd0, 32'hDEADBEEF, 1'b1, 64'd0, 1'b0, ack_seen);
        wait_idle();
        // all-ones squared
        issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE00000001, 1'b1, ack_seen);
        wait_idle();

        // both requesting after reset: requester 0 first, then 1
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        push_exp(1'b0, 64'h0000000100000000, 1'b1);
        push_exp(1'b1, 64'd1000000, 1'b0);
        fork
            issue(1'b0, 32'h00010000, 32'h00010000, 1'b0, 64'd0, 1'b0, ack_seen);
            issue(1'b1, 32'd1000, 32'd1000, 1'b0, 64'd0, 1'b0, ack_seen1);
        join
        chk("rr_order", 64'(ack_seen1 > ack_seen), 64'd1);
        wait_idle();

        // abort in RUN cycle 10; req1 presented during reset
        @(negedge clk);
        a0 = 32'h12345678; b0 = 32'd9; req0 = 1'b1;
        begin
            int n = 0;
            while (!ack0 && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) chk("abort_ack_timeout", 64'd1, 64'd0);
        end
        @(negedge clk); req0 = 1'b0;       // RUN cycle 1
        repeat (9) @(negedge clk);         // RUN cycle 10
        push_exp(1'b1, 64'h00000001FFFFFFFE, 1'b1);
        a1 = 32'hFFFFFFFF; b1 = 32'd2; req1 = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_product", product, 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_ack1", 64'(ack1), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ack1", 64'(ack1), 64'd1);
        @(negedge clk); req1 = 1'b0;
        wait_idle();

        // req1 raised while busy: acked in the cycle after first IDLE edge
        fork
            issue(1'b0, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1, ack_seen);
            begin
                wait_busy();
                issue(1'b1, 32'd12345, 32'd6789, 1'b1, 64'd83810205, 1'b0, ack_seen1);
            end
        join
        chk("late_req1_ack", 64'(ack_seen1 - done_cyc), 64'd2);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
